xlink_rx_decoder: RTL and testbench

- Receive-side front end of the 2-wire XLink.
- Samples the asynchronous wire pair rx_0/rx_1 and detects transitions. Decodes each group of 10 transitions into one 9-bit token: 8 value bits MSB first, one type bit, and a parity/return-to-zero symbol.
- Queues decoded tokens in a small FIFO toward the link-layer token consumer. Reports framing, parity, timeout and overflow errors as single-cycle pulses.

---
 rtl/xlink_rx_decoder_pkg.sv | 29 ++
 rtl/xlink_rx_sync.sv | 33 +++
 rtl/xlink_rx_decoder.sv | 182 ++++++++++++++++++
 tb/tb_xlink_rx_decoder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlink_rx_decoder_pkg.sv
// XLink receive decoder shared definitions.
// Token geometry, decoder state encoding and token assembly helper.
package xlink_rx_decoder_pkg;

  localparam int XLINK_TOKEN_W        = 9;
  localparam int XLINK_SYMS_PER_TOKEN = 10;
  localparam int XLINK_TYPE_BIT       = 8;

  typedef logic [XLINK_TOKEN_W-1:0] token_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } dec_state_e;

  // Symbols land MSB first: eight value bits,
  // then the type bit, then the parity symbol.
  function automatic token_t make_token(
    input logic [XLINK_SYMS_PER_TOKEN-1:0] sh
  );
    token_t t;
    t = '0;
    t[XLINK_TYPE_BIT]  = sh[1];
    t[7:0]             = sh[9:2];
    return t;
  endfunction

endpackage

// File: rtl/xlink_rx_sync.sv
// XLink wire-pair synchronizer and transition detector.
// Bit 0 is wire 0, bit 1 is wire 1.
module xlink_rx_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_0,
  input  logic       rx_1,
  output logic [1:0] sync,
  output logic [1:0] edges
);

  logic [1:0] meta;
  logic [1:0] prev;

  // Two-flop synchronizer plus a previous-value stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 2'b00;
      sync <= 2'b00;
      prev <= 2'b00;
    end else begin
      meta <= {rx_1, rx_0};
      sync <= meta;
      prev <= sync;
    end
  end

  // A set bit marks a wire that changed this cycle.
  always_comb begin
    edges = sync ^ prev;
  end

endmodule

// File: rtl/xlink_rx_decoder.sv
// XLink receive decoder: symbol assembly,
// error pulses and a small show-ahead token queue.
module xlink_rx_decoder
  import xlink_rx_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_0,
  input  logic       rx_1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_token,
  output logic       framing_err,
  output logic       parity_err,
  output logic       timeout_err,
  output logic       overflow,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE =
    TO_W'(1);
  localparam logic [3:0] CNT_LAST =
    4'(XLINK_SYMS_PER_TOKEN - 1);

  logic [1:0] sync;
  logic [1:0] edges;

  dec_state_e state, state_n;
  logic [3:0] count, count_n;
  logic [9:0] shift, shift_n;
  logic [TO_W-1:0] to_cnt, to_n;

  logic push;
  logic fe_n, pe_n, te_n, ov_n;

  token_t mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic full, empty, pop, wr_en;
  token_t token;

  xlink_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_0  (rx_0),
    .rx_1  (rx_1),
    .sync  (sync),
    .edges (edges)
  );

  assign token = make_token(shift);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && out_ready;
  assign wr_en = push && (!full || pop);

  assign out_valid = !empty;
  assign out_token = mem[rd_ptr[PW-1:0]];
  assign busy      = (count != 4'd0);

  // Decoder state register and symbol datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      count  <= 4'd0;
      shift  <= 10'd0;
      to_cnt <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      shift  <= shift_n;
      to_cnt <= to_n;
    end
  end

  // Next-state, symbol shifting and error detection.
  always_comb begin
    state_n = state;
    count_n = count;
    shift_n = shift;
    to_n    = to_cnt;
    push    = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
    te_n    = 1'b0;
    ov_n    = 1'b0;
    if (edges == 2'b11) begin
      fe_n    = 1'b1;
      state_n = ST_IDLE;
      count_n = 4'd0;
      shift_n = 10'd0;
      to_n    = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (edges != 2'b00) begin
            state_n = ST_RECV;
            count_n = 4'd1;
            shift_n = {9'd0, edges[1]};
            to_n    = '0;
          end
        end
        ST_RECV: begin
          if (edges != 2'b00) begin
            shift_n = {shift[8:0], edges[1]};
            count_n = count + 4'd1;
            to_n    = '0;
            if (count == CNT_LAST) begin
              state_n = ST_DONE;
            end
          end else if (to_cnt == TO_LAST) begin
            te_n    = 1'b1;
            state_n = ST_IDLE;
            count_n = 4'd0;
            shift_n = 10'd0;
            to_n    = '0;
          end else begin
            to_n = to_cnt + TO_ONE;
          end
        end
        ST_DONE: begin
          push    = 1'b1;
          pe_n    = (sync != 2'b00);
          ov_n    = full && !pop;
          state_n = ST_IDLE;
          count_n = 4'd0;
          shift_n = 10'd0;
          to_n    = '0;
        end
        default: begin
          state_n = ST_IDLE;
          count_n = 4'd0;
          shift_n = 10'd0;
          to_n    = '0;
        end
      endcase
    end
  end

  // Error pulses are registered for one clean cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      framing_err <= fe_n;
      parity_err  <= pe_n;
      timeout_err <= te_n;
      overflow    <= ov_n;
    end
  end

  // Token queue storage and wrap-bit pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[PW-1:0]] <= token;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xlink_rx_decoder.sv
// Bench for the XLink receive decoder.
// Drives wire transitions and checks decoded tokens and pulses.
module tb_xlink_rx_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_0;
  logic       rx_1;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_token;
  logic       framing_err;
  logic       parity_err;
  logic       timeout_err;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int fe_seen = 0;
  int pe_seen = 0;
  int to_seen = 0;
  int ov_seen = 0;
  bit rand_ready = 1'b0;

  xlink_rx_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .rx_0        (rx_0),
    .rx_1        (rx_1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_token   (out_token),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .timeout_err (timeout_err),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back(out_token);
      if (framing_err) fe_seen++;
      if (parity_err)  pe_seen++;
      if (timeout_err) to_seen++;
      if (overflow)    ov_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_sym(input bit s);
    if (s) rx_1 = ~rx_1;
    else   rx_0 = ~rx_0;
    tick();
    tick();
  endtask

  // Value MSB first, type, then a closing symbol that
  // returns the wires to 00 when possible (good=1) or not.
  task automatic send_token(input logic [8:0] tok, input bit good,
                            input bit chk_lat, input string nm,
                            output bit pe);
    logic [1:0] w;
    bit s;
    for (int i = 7; i >= 0; i--) send_sym(tok[i]);
    send_sym(tok[8]);
    w = {rx_1, rx_0};
    if (good) s = w[1];
    else      s = w[0];
    if (s) rx_1 = ~rx_1;
    else   rx_0 = ~rx_0;
    pe = ({rx_1, rx_0} != 2'b00);
    if (chk_lat) begin
      tick(); tick(); tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid got=%b want=0", nm, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s latency_valid got=%b want=1", nm, out_valid);
      end
    end else begin
      tick(); tick();
    end
  endtask

  task automatic drain_compare(input string nm);
    repeat (12) tick();
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s count got=%0d want=%0d", nm,
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s token[%0d] got=%h want=%h", nm, i,
                 got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic chk_outs_zero(input string nm);
    checks++;
    if ({out_valid, out_token, framing_err, parity_err,
         timeout_err, overflow, busy} !== 15'd0) begin
      errors++;
      $display("FAIL %s outs got=%b%h%b%b%b%b%b want=all zero", nm,
               out_valid, out_token, framing_err, parity_err,
               timeout_err, overflow, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_0 = 1'b0;
    rx_1 = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk_outs_zero("reset_hold");
    reset = 1'b0;
    repeat (3) tick();
    chk_outs_zero("reset_release");
  endtask

  task automatic test_hello();
    int e0 = fe_seen + pe_seen + to_seen + ov_seen;
    bit pe;
    send_token(9'h1E6, 1'b1, 1'b1, "hello", pe);
    exp_q.push_back(9'h1E6);
    drain_compare("hello");
    chk_int("hello_errs", fe_seen + pe_seen + to_seen + ov_seen, e0);
    chk_int("hello_busy", int'(busy), 0);
  endtask

  task automatic test_burst();
    logic [8:0] toks[$] = '{9'h17F, 9'h100, 9'h100, 9'h180};
    int pe0 = pe_seen;
    int pe_exp = 0;
    bit pe;
    repeat (4) toks.push_back(9'($urandom_range(0, 511)));
    foreach (toks[i]) begin
      send_token(toks[i], 1'b1, 1'b1, "burst", pe);
      exp_q.push_back(toks[i]);
      if (pe) pe_exp++;
    end
    drain_compare("burst");
    chk_int("burst_parity", pe_seen - pe0, pe_exp);
  endtask

  task automatic test_parity();
    int pe0 = pe_seen;
    int pe_exp = 0;
    bit pe;
    send_token(9'h1E4, 1'b0, 1'b1, "parity_bad", pe);
    exp_q.push_back(9'h1E4);
    if (pe) pe_exp++;
    send_token(9'h101, 1'b1, 1'b1, "parity_next", pe);
    exp_q.push_back(9'h101);
    if (pe) pe_exp++;
    drain_compare("parity");
    chk_int("parity_pulses", pe_seen - pe0, pe_exp);
    chk_int("parity_model_one", pe_exp, 1);
  endtask

  task automatic test_framing();
    int fe0 = fe_seen;
    logic [8:0] t = 9'($urandom_range(0, 511));
    bit pe;
    repeat (4) send_sym(1'($urandom_range(0, 1)));
    tick(); tick();
    chk_int("framing_busy_before", int'(busy), 1);
    rx_0 = ~rx_0;
    rx_1 = ~rx_1;
    repeat (5) tick();
    chk_int("framing_pulse", fe_seen - fe0, 1);
    chk_int("framing_busy_after", int'(busy), 0);
    send_token(t, 1'b1, 1'b1, "framing_next", pe);
    exp_q.push_back(t);
    drain_compare("framing");
  endtask

  task automatic test_timeout();
    int to0 = to_seen;
    int at = -1;
    bit pe;
    repeat (5) send_sym(1'($urandom_range(0, 1)));
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (timeout_err && at < 0) at = i;
    end
    chk_int("timeout_pulse", to_seen - to0, 1);
    chk_int("timeout_cycle", at, 1025);
    chk_int("timeout_busy", int'(busy), 0);
    send_token(9'h107, 1'b1, 1'b1, "timeout_next", pe);
    exp_q.push_back(9'h107);
    drain_compare("timeout");
  endtask

  task automatic test_overflow();
    int ov0 = ov_seen;
    bit pe;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_token(9'h100 + 9'(i), 1'b1, 1'b0, "ovf", pe);
      if (i <= 4) exp_q.push_back(9'h100 + 9'(i));
    end
    repeat (6) tick();
    chk_int("ovf_pulse", ov_seen - ov0, 1);
    checks++;
    if (out_token !== 9'h101) begin
      errors++;
      $display("FAIL ovf_head got=%h want=101", out_token);
    end
    out_ready = 1'b1;
    drain_compare("ovf_drain");
    chk_int("ovf_empty", int'(out_valid), 0);
  endtask

  task automatic test_reset_mid();
    int e0 = fe_seen + pe_seen + to_seen + ov_seen;
    bit pe;
    repeat (6) send_sym(1'($urandom_range(0, 1)));
    tick();
    chk_int("rstmid_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk_outs_zero("rstmid_async");
    rx_0 = 1'b0;
    rx_1 = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    send_token(9'h181, 1'b1, 1'b1, "rstmid_next", pe);
    exp_q.push_back(9'h181);
    drain_compare("rstmid");
    chk_int("rstmid_errs", fe_seen + pe_seen + to_seen + ov_seen, e0);
  endtask

  task automatic test_random();
    int pe0 = pe_seen;
    int ov0 = ov_seen;
    int pe_exp = 0;
    bit pe;
    logic [8:0] t;
    rand_ready = 1'b1;
    repeat (12) begin
      t = 9'($urandom_range(0, 511));
      send_token(t, 1'($urandom_range(0, 1)), 1'b0, "rand", pe);
      exp_q.push_back(t);
      if (pe) pe_exp++;
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain_compare("random");
    chk_int("random_parity", pe_seen - pe0, pe_exp);
    chk_int("random_ovf", ov_seen - ov0, 0);
  endtask

  initial begin
    test_reset();
    test_hello();
    test_burst();
    test_parity();
    test_framing();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
